qbert_pyramid_map: RTL

QBERT_PYRAMID_MAP -- requirements
Module: qbert_pyramid_map

---
 rtl/qbert_pyramid_map.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/qbert_pyramid_map.sv
// Qbert pyramid: per-cube geometry, 2-stage pixel colouring, cube colour
// state / level progress tracking and Qbert landing-box lookup.

// Per-cube geometry: face classification of the current pixel and landing box test.
module qbert_cube_hit #(
  parameter int XT         = 250,
  parameter int YT         = 190,
  parameter int XLENGTH    = 22,
  parameter int XDIAG_DEMI = 15,
  parameter int YDIAG_DEMI = 22
) (
  input  logic [10:0] x,
  input  logic [9:0]  y,
  input  logic [10:0] qx,
  input  logic [9:0]  qy,
  output logic        top,
  output logic        left,
  output logic        right,
  output logic        box
);
  int xi, yi, dx, dy, qdx, qdy;
  logic body;

  // Diamond top face, body split at mid-height, and landing box around top centre
  always_comb begin
    xi  = int'(x);
    yi  = int'(y);
    dx  = xi - XT;
    if (dx < 0) dx = -dx;
    dy  = yi - (YT + YDIAG_DEMI);
    if (dy < 0) dy = -dy;
    top = (dx * YDIAG_DEMI + dy * XDIAG_DEMI) <= (XDIAG_DEMI * YDIAG_DEMI);
    body = (xi > XT) && (xi <= XT + XDIAG_DEMI + XLENGTH) &&
           (yi >= YT) && (yi <= YT + 2 * YDIAG_DEMI);
    left  = body && !top && (yi <  YT + YDIAG_DEMI);
    right = body && !top && (yi >= YT + YDIAG_DEMI);
    qdx = int'(qx) - XT;
    if (qdx < 0) qdx = -qdx;
    qdy = int'(qy) - (YT + YDIAG_DEMI);
    if (qdy < 0) qdy = -qdy;
    box = (qdx <= XDIAG_DEMI / 2) && (qdy <= YDIAG_DEMI / 2);
  end
endmodule

module qbert_pyramid_map #(
  parameter int N_RANK     = 7,
  parameter int X0         = 250,
  parameter int Y0         = 190,
  parameter int XLENGTH    = 22,
  parameter int XDIAG_DEMI = 15,
  parameter int YDIAG_DEMI = 22,
  localparam int N_CUBE    = N_RANK * (N_RANK + 1) / 2,
  localparam int IDX_W     = $clog2(N_CUBE + 1)
) (
  input  logic                CLK_33,
  input  logic                reset,
  input  logic [10:0]         x_cnt,
  input  logic [9:0]          y_cnt,
  input  logic                e_pause,
  input  logic [1:0]          e_mode,
  input  logic                e_clear,
  input  logic                land_valid,
  input  logic [IDX_W-1:0]    land_idx,
  input  logic [20:0]         qbert_xy,
  input  logic                qb_pixel,
  input  logic [23:0]         qb_rgb,
  output logic [7:0]          red,
  output logic [7:0]          green,
  output logic [7:0]          blue,
  output logic                on_cube,
  output logic [IDX_W-1:0]    cube_idx,
  output logic [2*N_CUBE-1:0] color_state,
  output logic [IDX_W-1:0]    cubes_left,
  output logic                win
);
  localparam logic [IDX_W-1:0] N_CUBE_W = IDX_W'(N_CUBE);

  logic [N_CUBE-1:0] top_c, left_c, right_c, box_c;

  // One geometry instance per cube, rank r / position p -> index r(r+1)/2+p
  for (genvar r = 0; r < N_RANK; r++) begin : g_rank
    for (genvar p = 0; p <= r; p++) begin : g_pos
      localparam int K = r * (r + 1) / 2 + p;
      qbert_cube_hit #(
        .XT(X0 + r * (XDIAG_DEMI + XLENGTH)),
        .YT(Y0 - r * YDIAG_DEMI + p * 2 * YDIAG_DEMI),
        .XLENGTH(XLENGTH), .XDIAG_DEMI(XDIAG_DEMI), .YDIAG_DEMI(YDIAG_DEMI)
      ) u_cube (
        .x(x_cnt), .y(y_cnt), .qx(qbert_xy[20:10]), .qy(qbert_xy[9:0]),
        .top(top_c[K]), .left(left_c[K]), .right(right_c[K]), .box(box_c[K])
      );
    end
  end

  // ---------------- level state ----------------
  logic [N_CUBE-1:0][1:0] st, st_nxt;
  logic [1:0]             mode, mode_nxt, cur, nxt, tgt;
  logic [IDX_W-1:0]       cl_nxt;
  logic                   win_nxt;

  assign color_state = st;

  // Landing rule per mode, target tracking, clear has priority over landing
  always_comb begin
    st_nxt   = st;
    cl_nxt   = cubes_left;
    win_nxt  = win | (cubes_left == '0);
    mode_nxt = mode;
    cur      = 2'd0;
    nxt      = 2'd0;
    tgt      = (mode == 2'd1) ? 2'd2 : 2'd1;
    for (int k = 0; k < N_CUBE; k++)
      if (land_idx == IDX_W'(k)) cur = st[k];
    case (mode)
      2'd1:    nxt = (cur == 2'd2) ? 2'd2 : cur + 2'd1;
      2'd2:    nxt = (cur == 2'd1) ? 2'd0 : 2'd1;
      default: nxt = (cur == 2'd0) ? 2'd1 : cur;
    endcase
    if (e_clear) begin
      st_nxt   = '0;
      cl_nxt   = N_CUBE_W;
      win_nxt  = 1'b0;
      mode_nxt = (e_mode == 2'd3) ? 2'd0 : e_mode;
    end else if (land_valid && (land_idx < N_CUBE_W) && !win) begin
      for (int k = 0; k < N_CUBE; k++)
        if (land_idx == IDX_W'(k)) st_nxt[k] = nxt;
      if (cur != tgt && nxt == tgt) cl_nxt = cubes_left - 1'b1;
      else if (cur == tgt && nxt != tgt) cl_nxt = cubes_left + 1'b1;
    end
  end

  // Level state register; reset behaves like a clear
  always_ff @(posedge CLK_33) begin
    if (reset) begin
      st         <= '0;
      cubes_left <= N_CUBE_W;
      win        <= 1'b0;
      mode       <= (e_mode == 2'd3) ? 2'd0 : e_mode;
    end else begin
      st         <= st_nxt;
      cubes_left <= cl_nxt;
      win        <= win_nxt;
      mode       <= mode_nxt;
    end
  end

  // ---------------- landing box lookup ----------------
  logic             box_any;
  logic [IDX_W-1:0] box_sel;

  // Lowest matching index wins
  always_comb begin
    box_any = |box_c;
    box_sel = '0;
    for (int k = N_CUBE - 1; k >= 0; k--)
      if (box_c[k]) box_sel = IDX_W'(k);
  end

  // Registered Qbert-on-cube report
  always_ff @(posedge CLK_33) begin
    if (reset) begin
      on_cube  <= 1'b0;
      cube_idx <= '0;
    end else begin
      on_cube  <= box_any;
      cube_idx <= box_sel;
    end
  end

  // ---------------- render pipeline ----------------
  logic [N_CUBE-1:0] top_q, left_q, right_q;
  logic              qb_q, pause_q;
  logic [23:0]       qb_rgb_q;

  // Stage 1: per-cube face flags, sprite/pause delayed alongside
  always_ff @(posedge CLK_33) begin
    if (reset) begin
      top_q    <= '0;
      left_q   <= '0;
      right_q  <= '0;
      qb_q     <= 1'b0;
      pause_q  <= 1'b0;
      qb_rgb_q <= '0;
    end else begin
      top_q    <= top_c;
      left_q   <= left_c;
      right_q  <= right_c;
      qb_q     <= qb_pixel;
      pause_q  <= e_pause;
      qb_rgb_q <= qb_rgb;
    end
  end

  logic [1:0]  top_st;
  logic [23:0] base, pix;

  // Any top face beats any side face; among tops the lowest index picks the colour
  always_comb begin
    top_st = 2'd0;
    for (int k = N_CUBE - 1; k >= 0; k--)
      if (top_q[k]) top_st = st[k];
    if (qb_q)          base = qb_rgb_q;
    else if (|top_q)   base = (top_st == 2'd0) ? {8'd222, 8'd222, 8'd0} :
                              (top_st == 2'd1) ? {8'd86,  8'd70,  8'd239} :
                                                 {8'd237, 8'd28,  8'd36};
    else if (|left_q)  base = {8'd86, 8'd169, 8'd152};
    else if (|right_q) base = {8'd49, 8'd70,  8'd70};
    else               base = 24'd0;
    pix = base;
    if (pause_q)
      for (int c = 0; c < 3; c++)
        pix[c*8 +: 8] = (base[c*8 +: 8] > 8'd205) ? 8'd255 : base[c*8 +: 8] + 8'd50;
  end

  // Stage 2: output colour register
  always_ff @(posedge CLK_33) begin
    if (reset) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      red   <= pix[23:16];
      green <= pix[15:8];
      blue  <= pix[7:0];
    end
  end
endmodule
